paramtype_unpack: RTL and testbench

Type-parameterized stream deserializer: accepts a narrow beat stream of WIDTH-bit beats and reassembles values of parameterized type T, presented on a valid/ready output. It is the receiving end of a paramtype beat link and sits between a narrow transport and any consumer parameterized on T. Exercises type parameters whose defaults depend on other parameters, and `$bits` of a packed struct type.

---
 rtl/paramtype_pkg.sv | 10 +
 rtl/paramtype_unpack.sv | 94 +++++++++
 tb/tb_paramtype_unpack.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/paramtype_pkg.sv
// rtl/paramtype_pkg.sv - shared constants and helpers for the paramtype beat link.
package paramtype_pkg;

   localparam int PT_BEAT_WIDTH = 8;

   function automatic int beats_of(input int bits, input int width);
      return (bits + width - 1) / width;
   endfunction

endpackage

// File: rtl/paramtype_unpack.sv
// rtl/paramtype_unpack.sv - reassembles little-endian WIDTH-bit beats into values of type T.
// Optional PARAMTYPE_UNPACK_LAST_EN adds s_last framing and an err pulse on framing mismatch.
module paramtype_unpack
   import paramtype_pkg::*;
#(
   parameter type T      = logic [31:0],
   parameter int  WIDTH  = PT_BEAT_WIDTH,
   parameter type BEAT_T = logic [WIDTH-1:0],
   localparam int BEATS  = beats_of($bits(T), WIDTH)
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  s_valid,
   output logic  s_ready,
   input  BEAT_T s_data,
`ifdef PARAMTYPE_UNPACK_LAST_EN
   input  logic  s_last,
   output logic  err,
`endif
   output logic  m_valid,
   input  logic  m_ready,
   output T      m_data
);

   localparam int DW = $bits(T);
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
   localparam logic [DW-1:0] SLICE = DW'({WIDTH{1'b1}});

   logic [CW-1:0] cnt;
   logic [DW-1:0] acc;
   logic [DW-1:0] full;
   logic [DW-1:0] mask;
   logic [DW-1:0] rep;
   logic          at_last;
   logic          take;
   logic          fin;

   assign at_last = (cnt == LAST);
   assign s_ready = !at_last || !m_valid || m_ready;
   assign take    = s_valid && s_ready;

`ifdef PARAMTYPE_UNPACK_LAST_EN
   logic drop;
   logic wrap;
   assign fin  = take && at_last && s_last;
   assign drop = take && (at_last != s_last);
   assign wrap = at_last || s_last;
`else
   logic wrap;
   assign fin  = take && at_last;
   assign wrap = at_last;
`endif

   // Bits of the final beat beyond $bits(T) fall off the top of the DW-wide mask.
   always_comb begin
      mask = SLICE << (int'(cnt) * WIDTH);
      rep  = DW'({BEATS{s_data}});
      full = (acc & ~mask) | (rep & mask);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         acc <= '0;
      end else if (take) begin
         acc <= full;
         if (wrap) cnt <= '0;
         else      cnt <= cnt + 1'b1;
      end
   end

   // A final beat landing on the drain cycle keeps m_valid high with the new value.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= T'('0);
`ifdef PARAMTYPE_UNPACK_LAST_EN
         err     <= 1'b0;
`endif
      end else begin
         if (fin) begin
            m_valid <= 1'b1;
            m_data  <= T'(full);
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
`ifdef PARAMTYPE_UNPACK_LAST_EN
         err <= drop;
`endif
      end
   end

endmodule

// File: tb/tb_paramtype_unpack.sv
// tb/tb_paramtype_unpack.sv - scoreboard bench for paramtype_unpack (32-bit and 12-bit struct).
module tb_paramtype_unpack;

   typedef struct packed {
      logic [5:0] x;
      logic [5:0] y;
   } xy_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        s_valid = 1'b0;
   logic [7:0]  s_data  = 8'h00;
   logic        s_ready;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [31:0] m_data;

   logic        t_valid = 1'b0;
   logic [7:0]  t_data  = 8'h00;
   logic        t_ready;
   logic        tm_valid;
   logic        tm_ready = 1'b1;
   xy_t         tm_data;

`ifdef PARAMTYPE_UNPACK_LAST_EN
   logic s_last = 1'b0;
   logic t_last = 1'b0;
   logic err;
   logic t_err;
`endif

   paramtype_unpack #(.T(logic [31:0]), .WIDTH(8)) u_dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef PARAMTYPE_UNPACK_LAST_EN
      .s_last(s_last), .err(err),
`endif
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
   );

   paramtype_unpack #(.T(xy_t), .WIDTH(8)) u_dut12 (
      .clk(clk), .rst(rst),
      .s_valid(t_valid), .s_ready(t_ready), .s_data(t_data),
`ifdef PARAMTYPE_UNPACK_LAST_EN
      .s_last(t_last), .err(t_err),
`endif
      .m_valid(tm_valid), .m_ready(tm_ready), .m_data(tm_data)
   );

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   logic [31:0] exp32[$];
   logic [31:0] exp12[$];
   int hs_cyc[$];
   int stall[4];
   bit rnd_on = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitors sample mid-low-phase, after all bench drives for the coming edge have settled.
   always @(negedge clk) begin
      #3;
      if (!rst && m_valid && m_ready) begin
         hs_cyc.push_back(cyc);
         if (exp32.size() == 0) chk("m_unexpected32", m_data, 32'hxxxxxxxx);
         else chk("m_data32", m_data, exp32.pop_front());
      end
      if (!rst && tm_valid && tm_ready) begin
         if (exp12.size() == 0) chk("m_unexpected12", {20'd0, tm_data}, 32'hxxxxxxxx);
         else chk("m_data12", {20'd0, tm_data}, exp12.pop_front());
      end
   end

   // Called right after a negedge; returns right after the negedge following acceptance.
   task automatic beat32(input logic [7:0] d, input bit last, output int stalls);
      int n;
      n = 0;
      s_valid = 1'b1;
      s_data  = d;
`ifdef PARAMTYPE_UNPACK_LAST_EN
      s_last  = last;
`else
      if (last) n = 0;
`endif
      #1;
      while (!s_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("s_ready_timeout", 32'd0, 32'd1);
      stalls = n;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic send32(input logic [31:0] v, input int gapmax);
      for (int k = 0; k < 4; k++) begin
         repeat ($urandom_range(0, gapmax)) @(negedge clk);
         if (k == 3) exp32.push_back(v);
         beat32(8'((v >> (8 * k)) & 32'hFF), k == 3, stall[k]);
      end
   endtask

   task automatic beat12(input logic [7:0] d, input bit last);
      int n;
      n = 0;
      t_valid = 1'b1;
      t_data  = d;
`ifdef PARAMTYPE_UNPACK_LAST_EN
      t_last  = last;
`else
      if (last) n = 0;
`endif
      #1;
      while (!t_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("t_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      t_valid = 1'b0;
   endtask

   task automatic send12(input logic [15:0] raw);
      exp12.push_back({20'd0, raw[11:0]});
      beat12(raw[7:0], 1'b0);
      beat12(raw[15:8], 1'b1);
   endtask

   initial begin
      int base;
      int s;
      logic [31:0] v;
      repeat (2) @(negedge clk);
      chk("reset_s_ready", {31'd0, s_ready}, 32'd1);
      chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
      chk("reset_m_data", m_data, 32'd0);
      rst = 1'b0;

      // Basic word with immediate drain: one-cycle m_valid pulse.
      send32(32'h44332211, 0);
      chk("basic_m_valid", {31'd0, m_valid}, 32'd1);
      chk("basic_m_data", m_data, 32'h44332211);
      @(negedge clk);
      chk("basic_pulse_end", {31'd0, m_valid}, 32'd0);

      // Struct T: upper nibble of the last beat is discarded.
      send12(16'hFACD);
      chk("xy_m_data", {20'd0, tm_data}, 32'h00000ACD);
      for (int i = 0; i < 8; i++) send12(16'($urandom));

      // Backpressure: only word 2's final beat stalls.
      m_ready = 1'b0;
      send32(32'hA1B2C3D4, 0);
      fork
         begin repeat (4) @(negedge clk); m_ready = 1'b1; end
      join_none
      send32(32'h0BADF00D, 0);
      chk("bp_nonfinal_stalls", stall[0] + stall[1] + stall[2], 32'd0);
      chk("bp_final_stalled", {31'd0, stall[3] != 0}, 32'd1);
      chk("bp_word2_held", m_data, 32'h0BADF00D);
      repeat (2) @(negedge clk);

      // Continuous stream: handshakes exactly BEATS cycles apart.
      base = hs_cyc.size();
      for (int i = 0; i < 3; i++) send32($urandom, 0);
      repeat (2) @(negedge clk);
      chk("stream_count", hs_cyc.size() - base, 32'd3);
      if (hs_cyc.size() - base == 3) begin
         chk("stream_gap0", hs_cyc[base + 1] - hs_cyc[base], 32'd4);
         chk("stream_gap1", hs_cyc[base + 2] - hs_cyc[base + 1], 32'd4);
      end

      // Reset mid-word discards the partial beats.
      beat32(8'hAA, 1'b0, s);
      beat32(8'hBB, 1'b0, s);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      send32(32'h04030201, 0);
      chk("rst_next_word", m_data, 32'h04030201);

`ifdef PARAMTYPE_UNPACK_LAST_EN
      @(negedge clk);
      beat32(8'h01, 1'b0, s);
      beat32(8'h02, 1'b1, s);
      chk("early_last_err", {31'd0, err}, 32'd1);
      chk("early_last_no_valid", {31'd0, m_valid}, 32'd0);
      @(negedge clk);
      chk("err_one_cycle", {31'd0, err}, 32'd0);
      for (int k = 0; k < 4; k++) beat32(8'(k + 5), 1'b0, s);
      chk("missing_last_err", {31'd0, err}, 32'd1);
      chk("missing_last_no_valid", {31'd0, m_valid}, 32'd0);
      send32(32'hCAFE1234, 0);
      chk("after_err_word", m_data, 32'hCAFE1234);
`endif

      // Randomized traffic with random consumer stalls and source gaps.
      rnd_on = 1;
      fork
         while (rnd_on) begin
            @(negedge clk);
            m_ready = 1'($urandom_range(0, 1));
         end
      join_none
      for (int i = 0; i < 25; i++) begin
         v = $urandom;
         send32(v, 2);
      end
      rnd_on = 0;
      @(negedge clk);
      m_ready = 1'b1;

      for (int i = 0; i < 100 && (exp32.size() != 0 || exp12.size() != 0); i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("drain32", exp32.size(), 32'd0);
      chk("drain12", exp12.size(), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
